// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  // Default multi-cycle EX latency and the width of its down-counter
  localparam int MDU_LAT_DEF = 4;
  localparam int MDU_CNT_W   = 8;

  // Value loaded into the MDU down-counter: the start cycle and the
  // zero-count exit cycle together account for two of the latency cycles.
  function automatic logic [MDU_CNT_W-1:0] mdu_load_value(input int lat);
    mdu_load_value = MDU_CNT_W'(lat - 2);
  endfunction

endpackage

// File: rtl/pipe_ctrl_rise_det.sv
// Rising-edge detector for a level that is already synchronous to clk.
// A level that is high when history is captured never reports an edge
// until it has been seen low first.
module rise_det (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic rise
);

  logic r_prev;

  // Remember the previous-cycle level; cleared to 0 by reset
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= d;
    end
  end

  assign rise = d & ~r_prev;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / stall controller: load-use stalls, branch flushes,
// multi-cycle MDU wait and syscall halt with go-button resume.
// Optional stall counter enabled by defining PIPE_CTRL_STALL_CNT_EN;
// without it stall_cnt is constant zero and no counter flops exist.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             mdu_start,
  input  logic             halt_req,
  input  logic             go,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             exmem_clr,
  output logic             halted,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [MDU_CNT_W-1:0] MDU_LOAD = mdu_load_value(MDU_LAT);
  localparam logic [MDU_CNT_W-1:0] MDU_ONE  = {{(MDU_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [MDU_CNT_W-1:0] MDU_ZERO = {MDU_CNT_W{1'b0}};

  state_t               r_state;
  state_t               w_next_state;
  logic [MDU_CNT_W-1:0] r_cnt;
  logic [MDU_CNT_W-1:0] w_next_cnt;
  logic                 r_halted;
  logic                 r_mdu_done;
  logic                 w_go_rise;

  logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
  logic w_ifid_clr, w_idex_clr, w_exmem_clr;

  rise_det u_go_rise (
    .clk  (clk),
    .clr  (clr),
    .d    (go),
    .rise (w_go_rise)
  );

  // State, MDU counter and registered status flags
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= ST_RUN;
      r_cnt      <= MDU_ZERO;
      r_halted   <= 1'b0;
      r_mdu_done <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_halted   <= (w_next_state == ST_HALT);
      // Pulse during the final MDU_WAIT cycle (the one seeing count 0)
      r_mdu_done <= (w_next_state == ST_MDU_WAIT) && (w_next_cnt == MDU_ZERO);
    end
  end

  // Next-state logic and combinational pipeline enables/flushes
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_idex_en    = 1'b1;
    w_exmem_en   = 1'b1;
    w_memwb_en   = 1'b1;
    w_ifid_clr   = 1'b0;
    w_idex_clr   = 1'b0;
    w_exmem_clr  = 1'b0;
    case (r_state)
      ST_RUN: begin
        // Priority: halt > mdu > branch > load-use
        if (halt_req) begin
          w_next_state = ST_HALT;
        end else if (mdu_start) begin
          w_next_state = ST_MDU_WAIT;
          w_next_cnt   = MDU_LOAD;
        end else if (branch_taken) begin
          w_ifid_clr = 1'b1;
          w_idex_clr = 1'b1;
        end else if (load_use) begin
          w_pc_en    = 1'b0;
          w_ifid_en  = 1'b0;
          w_idex_clr = 1'b1;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_MDU_WAIT: begin
        // Freeze front end, push bubbles into EX/MEM, let older work drain
        w_pc_en     = 1'b0;
        w_ifid_en   = 1'b0;
        w_idex_en   = 1'b0;
        w_exmem_clr = 1'b1;
        if (r_cnt == MDU_ZERO) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_cnt = r_cnt - MDU_ONE;
        end
      end
      ST_HALT: begin
        w_pc_en    = 1'b0;
        w_ifid_en  = 1'b0;
        w_idex_en  = 1'b0;
        w_exmem_en = 1'b0;
        w_memwb_en = 1'b0;
        if (w_go_rise) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_HALT;
        end
      end
      default: begin
        w_next_state = ST_RUN;
        w_next_cnt   = MDU_ZERO;
      end
    endcase
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_stall_cnt;

  // Count frozen-PC cycles outside HALT, saturating at all-ones
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (!w_pc_en && (r_state != ST_HALT) && (r_stall_cnt != STALL_MAX)) begin
      r_stall_cnt <= r_stall_cnt + STALL_ONE;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = {CNT_W{1'b0}};
`endif

  assign pc_en     = w_pc_en;
  assign ifid_en   = w_ifid_en;
  assign idex_en   = w_idex_en;
  assign exmem_en  = w_exmem_en;
  assign memwb_en  = w_memwb_en;
  assign ifid_clr  = w_ifid_clr;
  assign idex_clr  = w_idex_clr;
  assign exmem_clr = w_exmem_clr;
  assign halted    = r_halted;
  assign mdu_done  = r_mdu_done;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl (MDU_LAT=4, CNT_W=4).
// Stall-count expectations follow PIPE_CTRL_STALL_CNT_EN if defined.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_STALL_CNT_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr, load_use, branch_taken, mdu_start, halt_req, go;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_clr, idex_clr, exmem_clr, halted, mdu_done;
  logic [3:0] stall_cnt;
  logic [7:0] ctl;

  int errors = 0;
  int checks = 0;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_clr, exmem_clr}
  localparam logic [7:0] C_IDLE = 8'b11111_000;
  localparam logic [7:0] C_LU   = 8'b00111_010;
  localparam logic [7:0] C_BR   = 8'b11111_110;
  localparam logic [7:0] C_MDU  = 8'b00011_001;
  localparam logic [7:0] C_HALT = 8'b00000_000;

  always #5 clk = ~clk;

  pipe_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .clr(clr), .load_use(load_use), .branch_taken(branch_taken),
    .mdu_start(mdu_start), .halt_req(halt_req), .go(go),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
    .exmem_clr(exmem_clr), .halted(halted), .mdu_done(mdu_done),
    .stall_cnt(stall_cnt)
  );

  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_clr, exmem_clr};

  typedef struct {
    string      name;
    logic       lu, br, mdu, hlt, g;
    logic [7:0] exp_ctl;
    logic       exp_halted;
    int         exp_stall;   // value after one edge when the counter is built in
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_st(input int n);
    return STALL_ON ? n : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_use = 1'b0; branch_taken = 1'b0; mdu_start = 1'b0; halt_req = 1'b0; go = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"idle",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE, 1'b0, 0};
    vecs[1] = '{"load_use",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU,   1'b0, 1};
    vecs[2] = '{"branch",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_BR,   1'b0, 0};
    vecs[3] = '{"br_lu",     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_BR,   1'b0, 0};
    vecs[4] = '{"mdu_lu_br", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, C_IDLE, 1'b0, 0};
    vecs[5] = '{"halt_all",  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, C_IDLE, 1'b1, 0};
    vecs[6] = '{"halt",      1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_IDLE, 1'b1, 0};
    vecs[7] = '{"go_run",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_IDLE, 1'b0, 0};
    vecs[8] = '{"lu_go",     1'b1, 1'b0, 1'b0, 1'b0, 1'b1, C_LU,   1'b0, 1};

    // Reset state, with clr held high
    idle_inputs();
    clr = 1'b1;
    #2;
    check("rst_ctl", 32'(ctl), 32'(C_IDLE));
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_mdu_done", 32'(mdu_done), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    tick();
    clr = 1'b0;

    // Single-cycle RUN vectors, each from a fresh reset
    for (int i = 0; i < 9; i++) begin
      do_reset();
      load_use = vecs[i].lu; branch_taken = vecs[i].br; mdu_start = vecs[i].mdu;
      halt_req = vecs[i].hlt; go = vecs[i].g;
      #1;
      check({vecs[i].name, "_ctl"}, 32'(ctl), 32'(vecs[i].exp_ctl));
      tick();
      idle_inputs();
      check({vecs[i].name, "_halted"}, 32'(halted), 32'(vecs[i].exp_halted));
      check({vecs[i].name, "_stall"}, 32'(stall_cnt), 32'(exp_st(vecs[i].exp_stall)));
    end

    // MDU wait: start in cycle 0, stall cycles 1..3, done in 3, RUN in 4
    do_reset();
    mdu_start = 1'b1;
    #1;
    check("mdu_c0_ctl", 32'(ctl), 32'(C_IDLE));
    tick();
    mdu_start = 1'b0;
    check("mdu_c1_ctl", 32'(ctl), 32'(C_MDU));
    check("mdu_c1_done", 32'(mdu_done), 32'd0);
    tick();
    // Every event is ignored while waiting
    load_use = 1'b1; branch_taken = 1'b1; mdu_start = 1'b1; halt_req = 1'b1;
    #1;
    check("mdu_c2_ctl", 32'(ctl), 32'(C_MDU));
    check("mdu_c2_done", 32'(mdu_done), 32'd0);
    tick();
    idle_inputs();
    check("mdu_c3_ctl", 32'(ctl), 32'(C_MDU));
    check("mdu_c3_done", 32'(mdu_done), 32'd1);
    check("mdu_c3_halted", 32'(halted), 32'd0);
    tick();
    check("mdu_c4_ctl", 32'(ctl), 32'(C_IDLE));
    check("mdu_c4_done", 32'(mdu_done), 32'd0);
    check("mdu_c4_stall", 32'(stall_cnt), 32'(exp_st(3)));

    // Halt with go held high from before: must not resume until a fresh rise
    do_reset();
    go = 1'b1;
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt_ctl", 32'(ctl), 32'(C_HALT));
    check("halt_flag", 32'(halted), 32'd1);
    repeat (3) tick();
    check("halt_go_held", 32'(halted), 32'd1);
    go = 1'b0;
    tick();
    check("halt_go_low", 32'(halted), 32'd1);
    go = 1'b1;
    #1;
    check("halt_rise_cycle", 32'(halted), 32'd1);
    tick();
    check("resume_halted", 32'(halted), 32'd0);
    check("resume_ctl", 32'(ctl), 32'(C_IDLE));
    check("halt_stall", 32'(stall_cnt), 32'd0);
    go = 1'b0;

    // clr in cycle 2 of MDU_WAIT: back to RUN, no done pulse afterwards
    begin
      int done_seen;
      done_seen = 0;
      do_reset();
      mdu_start = 1'b1;
      tick();
      mdu_start = 1'b0;
      tick();
      clr = 1'b1;
      #1;
      check("clr_mdu_ctl", 32'(ctl), 32'(C_IDLE));
      check("clr_mdu_stall", 32'(stall_cnt), 32'd0);
      check("clr_mdu_done", 32'(mdu_done), 32'd0);
      tick();
      clr = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (mdu_done === 1'b1) done_seen++;
        tick();
      end
      check("clr_mdu_no_done", 32'(done_seen), 32'd0);
      check("clr_mdu_run", 32'(ctl), 32'(C_IDLE));
    end

    // Stall counter saturation with load_use held 20 cycles
    do_reset();
    load_use = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("sat_%0d", k), 32'(stall_cnt), 32'(exp_st(k > 15 ? 15 : k)));
    end
    load_use = 1'b0;
    tick();
    check("sat_hold", 32'(stall_cnt), 32'(exp_st(15)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MDU_LAT, default 4, multi-cycle EX (mul/div) latency in cycles, legal 2..255.
REQ-002 SHALL have parameter CNT_W, default 32, stall counter width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 clr  in  1  reset, asynchronous, active-high.
REQ-005 load_use  in  1  load-use hazard detected in ID.
REQ-006 branch_taken  in  1  taken branch/jump resolved in EX.
REQ-007 mdu_start  in  1  multi-cycle instruction entering EX, 1-cycle pulse.
REQ-008 halt_req  in  1  syscall-halt instruction in EX.
REQ-009 go  in  1  resume button level, already synchronised to clk.
REQ-010 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables.
REQ-011 ifid_clr, idex_clr, exmem_clr  out  1 each  flush (bubble) requests, sampled by pipeline registers at the next edge.
REQ-012 halted  out  1  processor halted; mdu_done  out  1  one-cycle pulse at MDU_WAIT exit.
REQ-013 stall_cnt  out  CNT_W  stall cycle count.

Function
REQ-014 SHALL implement FSM states RUN, MDU_WAIT, HALT; enables/flushes combinational from state and inputs.
REQ-015 RUN, no event: all enables 1, all flushes 0.
REQ-016 RUN, event priority halt_req > mdu_start > branch_taken > load_use; lower events ignored that cycle.
REQ-017 RUN+load_use: pc_en=0, ifid_en=0, idex_clr=1, others normal; stays RUN.
REQ-018 RUN+branch_taken: ifid_clr=1, idex_clr=1, pc_en=1; stays RUN.
REQ-019 RUN+mdu_start: all enables normal this cycle; next state MDU_WAIT, counter loaded MDU_LAT-2.
REQ-020 MDU_WAIT: pc_en=ifid_en=idex_en=0, exmem_clr=1, memwb_en=1; counter decrements; at counter 0, next state RUN with mdu_done=1 for that one cycle (total EX occupancy MDU_LAT cycles).
REQ-021 MDU_WAIT SHALL ignore load_use, branch_taken, mdu_start, halt_req.
REQ-022 RUN+halt_req: current cycle normal enables; next state HALT.
REQ-023 HALT: all enables 0, flushes 0, halted=1; exit to RUN on go rising edge (go=1 while previous-cycle go=0); go held high from before HALT entry SHALL NOT resume.
REQ-024 halted and mdu_done SHALL be registered outputs.

Reset
REQ-025 clr=1 SHALL immediately force state RUN, counter 0, go history 0, halted=0, mdu_done=0, stall_cnt=0, including mid-MDU_WAIT or HALT.
REQ-026 With clr=1 and no events, enable/flush outputs SHALL show RUN idle values.

Configuration
REQ-027 Macro PIPE_CTRL_STALL_CNT_EN defined: stall_cnt increments each cycle with pc_en=0 and state!=HALT, saturating at 2^CNT_W-1.
REQ-028 Macro undefined: stall_cnt tied 0, no counter flops.

Structure
REQ-029 Package pipe_ctrl_pkg SHALL hold state enum type and default MDU_LAT constant.
REQ-030 Sub-module rise_det (go edge detector, clk/clr) SHALL be instantiated once.

Verification
REQ-031 RUN, load_use=1 one cycle -> pc_en=0, ifid_en=0, idex_clr=1 that cycle; stall_cnt=1 (macro on).
REQ-032 branch_taken=1 and load_use=1 same cycle -> ifid_clr=1, idex_clr=1, pc_en=1.
REQ-033 MDU_LAT=4, mdu_start pulse at cycle 0 -> pc_en=0 cycles 1..3, mdu_done=1 cycle 3, RUN cycle 4; stall_cnt=3.
REQ-034 halt_req with go held 1 -> halted=1, stays HALT; go 0 then 1 -> RUN next cycle, halted=0.
REQ-035 clr pulse at cycle 2 of MDU_WAIT -> state RUN, all enables 1, stall_cnt=0, mdu_done never pulses.
REQ-036 CNT_W=4, load_use held 20 cycles -> stall_cnt saturates at 15; macro off -> stall_cnt=0 throughout.
